// File: rtl/flowing_pkg.sv
// ============================================================================
// Module   : flowing_pkg
// Brief    : Shared types and constants for the flowing-LED step controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flowing_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef logic [1:0] speed_t;

    function automatic logic flip_dir(input logic d);
        return (d == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-FF synchroniser plus counter debouncer; emits a 1-cycle press
//            pulse on the accepted 0->1 transition.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DB_CNT);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DB_CNT - 1));

    // The counter only advances while the synchronised input disagrees with
    // the accepted level; any agreeing sample restarts the qualification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (w_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/flowing_step_ctrl.sv
// ============================================================================
// Module   : flowing_step_ctrl
// Brief    : Step-pulse divider, run/pause FSM and direction control for the
//            flowing-LED shifter. Macro FLOW_SPEED_SEL_EN adds speed select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flowing_step_ctrl
    import flowing_pkg::*;
#(
    parameter int STEP_DIV = 25_000_000,
    parameter int DB_CNT   = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_dir,
    input  logic       btn_speed,
    output logic       step,
    output logic       dir,
    output logic       running,
    output logic [1:0] speed
);

    localparam int DW = $clog2(STEP_DIV);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_running;
    logic          w_running_nxt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_max;
    logic          w_terminal;
    logic          r_step;
    logic          r_dir;
    speed_t        w_speed;
    logic          w_speed_chg;
    logic          w_pause_press;
    logic          w_dir_press;
    logic          w_pause_level_unused;
    logic          w_dir_level_unused;

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_pause),
        .level (w_pause_level_unused),
        .press (w_pause_press)
    );

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_dir (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_dir),
        .level (w_dir_level_unused),
        .press (w_dir_press)
    );

`ifdef FLOW_SPEED_SEL_EN
    speed_t r_speed;
    logic   w_speed_press;
    logic   w_speed_level_unused;

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_speed (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_speed),
        .level (w_speed_level_unused),
        .press (w_speed_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_speed <= '0;
        end else if (w_speed_press) begin
            r_speed <= r_speed + 1'b1;
        end
    end

    assign w_speed     = r_speed;
    assign w_speed_chg = w_speed_press;
`else
    logic w_btn_speed_unused;

    assign w_btn_speed_unused = btn_speed;
    assign w_speed            = '0;
    assign w_speed_chg        = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= w_running_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_pause_press) begin
            w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    // FSM: outputs, registered so running flips on the press edge itself
    always_comb begin
        w_running_nxt = (w_state_nxt == ST_RUN);
    end

    assign w_div_max  = DW'((STEP_DIV >> w_speed) - 1);
    assign w_terminal = (r_state == ST_RUN) && (r_div == w_div_max);

    // Decisions use the current state, so a pause arriving on the terminal
    // count still releases that step and leaves the divider parked at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_step <= 1'b0;
        end else if (w_speed_chg) begin
            r_div  <= '0;
            r_step <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_div  <= w_terminal ? '0 : r_div + 1'b1;
            r_step <= w_terminal;
        end else begin
            r_step <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir <= DIR_LEFT;
        end else if (w_dir_press) begin
            r_dir <= flip_dir(r_dir);
        end
    end

    assign step    = r_step;
    assign dir     = r_dir;
    assign running = r_running;
    assign speed   = w_speed;

endmodule

`default_nettype wire

// File: tb/tb_flowing_step_ctrl.sv
// ============================================================================
// Module   : tb_flowing_step_ctrl
// Brief    : Directed self-checking bench for flowing_step_ctrl
//            (STEP_DIV=16, DB_CNT=4, 10 ns clock).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flowing_step_ctrl;

    localparam int STEP_DIV = 16;
    localparam int DB_CNT   = 4;
    localparam int PRESS_LAT = DB_CNT + 3;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_dir   = 1'b0;
    logic       btn_speed = 1'b0;
    logic       step;
    logic       dir;
    logic       running;
    logic [1:0] speed;

    int n_vec = 0;
    int n_err = 0;
    int n;

    always #5 clk = ~clk;

    flowing_step_ctrl #(
        .STEP_DIV (STEP_DIV),
        .DB_CNT   (DB_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_dir   (btn_dir),
        .btn_speed (btn_speed),
        .step      (step),
        .dir       (dir),
        .running   (running),
        .speed     (speed)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge.
    task automatic cyc(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    // Cycles until the next step pulse; -1 if none within the budget.
    task automatic wait_step(output int cnt);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (step !== 1'b1 && cnt < 200);
        if (step !== 1'b1) cnt = -1;
    endtask

    task automatic count_steps(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc(1);
            if (step === 1'b1) cnt++;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        cyc(3);
        check_val("rst_step", step, 0);
        check_val("rst_dir", dir, 0);
        check_val("rst_running", running, 1);
        check_val("rst_speed", speed, 0);

        // First step 16 cycles after release, then period 16
        rst = 1'b0;
        wait_step(n);
        check_val("first_step", n, STEP_DIV);
        check_val("first_dir", dir, 0);
        check_val("first_running", running, 1);
        wait_step(n);
        check_val("period", n, STEP_DIV);

        // 2-cycle glitch on pause is rejected
        btn_pause = 1'b1;
        cyc(2);
        btn_pause = 1'b0;
        cyc(10);
        check_val("glitch_running", running, 1);

        // Real pause press launched right after a step: divider holds 7
        wait_step(n);
        btn_pause = 1'b1;
        cyc(PRESS_LAT - 1);
        check_val("pause_lat_early", running, 1);
        cyc(1);
        check_val("pause_lat", running, 0);
        cyc(3);
        btn_pause = 1'b0;
        count_steps(100, n);
        check_val("pause_no_step", n, 0);
        check_val("pause_held", running, 0);

        // Resume: first step after 16 - 7 cycles, button still held
        btn_pause = 1'b1;
        cyc(PRESS_LAT - 1);
        check_val("resume_lat_early", running, 0);
        cyc(1);
        check_val("resume_lat", running, 1);
        wait_step(n);
        check_val("resume_first", n, STEP_DIV - PRESS_LAT);
        btn_pause = 1'b0;
        wait_step(n);
        check_val("resume_period", n, STEP_DIV);

        // Dir press while running; step cadence unaffected
        wait_step(n);
        btn_dir = 1'b1;
        cyc(PRESS_LAT - 1);
        check_val("dir_lat_early", dir, 0);
        cyc(1);
        check_val("dir_lat", dir, 1);
        cyc(3);
        btn_dir = 1'b0;
        wait_step(n);
        check_val("dir_period", n, STEP_DIV - 10);

        // Dir press landing on the terminal-count edge
        cyc(9);
        btn_dir = 1'b1;
        cyc(PRESS_LAT - 1);
        check_val("tc_pre_step", step, 0);
        check_val("tc_pre_dir", dir, 1);
        cyc(1);
        check_val("tc_step", step, 1);
        check_val("tc_dir", dir, 0);
        cyc(4);
        btn_dir = 1'b0;
        cyc(8);

        // Set dir=1 and pause with divider held at 9, then reset mid-cycle
        btn_dir = 1'b1;
        cyc(10);
        btn_dir = 1'b0;
        cyc(8);
        check_val("dir_set", dir, 1);
        wait_step(n);
        cyc(2);
        btn_pause = 1'b1;
        cyc(PRESS_LAT);
        check_val("pause9_running", running, 0);
        cyc(3);
        btn_pause = 1'b0;
        cyc(10);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_step", step, 0);
        check_val("arst_dir", dir, 0);
        check_val("arst_running", running, 1);
        check_val("arst_speed", speed, 0);
        cyc(2);
        rst = 1'b0;
        wait_step(n);
        check_val("post_rst_first", n, STEP_DIV);

`ifdef FLOW_SPEED_SEL_EN
        for (int i = 1; i <= 4; i++) begin
            btn_speed = 1'b1;
            cyc(PRESS_LAT);
            check_val("speed_val", speed, i % 4);
            check_val("speed_chg_nostep", step, 0);
            wait_step(n);
            check_val("speed_first", n, STEP_DIV >> (i % 4));
            wait_step(n);
            check_val("speed_period", n, STEP_DIV >> (i % 4));
            btn_speed = 1'b0;
            cyc(8);
        end
`else
        btn_speed = 1'b1;
        cyc(10);
        btn_speed = 1'b0;
        cyc(8);
        check_val("speed_ignored", speed, 0);
        wait_step(n);
        wait_step(n);
        check_val("speed_ign_period", n, STEP_DIV);
`endif

        // Simultaneous pause and dir presses take effect together
        btn_pause = 1'b1;
        btn_dir   = 1'b1;
        cyc(PRESS_LAT - 1);
        check_val("both_early_running", running, 1);
        check_val("both_early_dir", dir, 0);
        cyc(1);
        check_val("both_running", running, 0);
        check_val("both_dir", dir, 1);
        cyc(3);
        btn_pause = 1'b0;
        btn_dir   = 1'b0;
        count_steps(40, n);
        check_val("both_no_step", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
